// File: rtl/demux4_stream.sv
// -----------------------------------------------------------------------------
// demux4_stream
//   Registered 1-to-4 valid/ready stream demultiplexer. Each input word is
//   steered by in_sel into one of four single-entry output registers. Every
//   channel also keeps a saturating count of words its consumer has taken.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input word present
//   in_ready   input accepted this cycle (combinational from out_valid/out_ready/in_sel)
//   in_sel     destination channel 0..3
//   in_data    input word
//   out_valid  per-channel word-held flags
//   out_ready  per-channel consumer ready
//   out_data   channel k word on [k*WIDTH +: WIDTH]
//   cnt        channel k delivery count on [k*CNT_W +: CNT_W]
//   cnt_clr    synchronous clear of all four counters
// -----------------------------------------------------------------------------
module demux4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [4*CNT_W-1:0] cnt,
  input  logic               cnt_clr
);

  logic [3:0]       vld_q, vld_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [3:0]       deliver;
  logic             xfer;

  // Saturating increment: sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + 1'b1;
  endfunction

  // A full channel can still accept when its consumer drains it in the same
  // cycle, which is what gives back-to-back throughput into one channel.
  assign in_ready = !vld_q[in_sel] || out_ready[in_sel];
  assign xfer     = in_valid && in_ready;

  always_comb begin
    vld_d    = vld_q;
    deliver  = vld_q & out_ready;
    out_data = '0;
    cnt      = '0;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];

      // Refill has priority over drain so a same-cycle drain+refill keeps valid high.
      if (xfer && (in_sel == 2'(k))) begin
        data_d[k] = in_data;
        vld_d[k]  = 1'b1;
      end else if (deliver[k]) begin
        vld_d[k]  = 1'b0;
      end

      if (cnt_clr)         cnt_d[k] = '0;
      else if (deliver[k]) cnt_d[k] = sat_inc(cnt_q[k]);

      out_data[k*WIDTH +: WIDTH] = data_q[k];
      cnt[k*CNT_W +: CNT_W]      = cnt_q[k];
    end
  end

  assign out_valid = vld_q;

  // Single register stage: all channel state.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [4*CNT_W-1:0] cnt;
  logic               cnt_clr;

  always #5 clk = ~clk;

  demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt(cnt), .cnt_clr(cnt_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is a FIFO of at most one word, plus the
  // last word written (the data bus holds it after draining) and a count.
  logic [7:0] mq [4][$];
  logic [7:0] mlast [4];
  int         mcnt [4];
  bit         known = 0;

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (mq[k].size() > 0);
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = mlast[k];
    return d;
  endfunction

  function automatic logic [15:0] exp_cnt();
    logic [15:0] c;
    for (int k = 0; k < 4; k++) c[k*4 +: 4] = 4'(mcnt[k]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare everything against the model just
  // before the edge, then advance the model across the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] ord, input logic clr);
    bit acc;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ord; cnt_clr = clr;
    @(negedge clk);
    acc = v && ((mq[s].size() == 0) || ord[s]);
    if (known) begin
      chk("in_ready", 64'(in_ready), 64'((mq[s].size() == 0) || ord[s]));
      chk("out_valid", 64'(out_valid), 64'(exp_valid()));
      chk("out_data", 64'(out_data), 64'(exp_data()));
      chk("cnt", 64'(cnt), 64'(exp_cnt()));
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete(); mlast[k] = 8'h00; mcnt[k] = 0;
      end
      known = 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() > 0 && ord[k]) begin
          void'(mq[k].pop_front());
          if (mcnt[k] < CMAX) mcnt[k]++;
        end
        if (clr) mcnt[k] = 0;
      end
      if (acc) begin
        mq[s].push_back(d);
        mlast[s] = d;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hFF;
    out_ready = 4'hF; cnt_clr = 1'b0;

    // Reset for two cycles with a word presented (it must be lost)
    step(1, 1, 2'd1, 8'h99, 4'hF, 0);
    step(1, 1, 2'd2, 8'h98, 4'hF, 0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);

    // Basic routing
    step(0, 1, 2'd0, 8'hA0, 4'hF, 0);
    chk("route0", 64'({out_valid, out_data[7:0]}), 64'({4'b0001, 8'hA0}));
    step(0, 1, 2'd1, 8'hB1, 4'hF, 0);
    step(0, 1, 2'd2, 8'hC2, 4'hF, 0);
    step(0, 1, 2'd3, 8'hD3, 4'hF, 0);
    chk("route3", 64'({out_valid, out_data[31:24]}), 64'({4'b1000, 8'hD3}));
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);
    chk("cnt_all_one", 64'(cnt), 64'h1111);

    // Backpressure on channel 2
    step(0, 1, 2'd2, 8'h11, 4'b1011, 0);
    step(0, 1, 2'd2, 8'h22, 4'b1011, 0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_hold", 64'(out_data[23:16]), 64'h11);
    step(0, 1, 2'd2, 8'h22, 4'b1011, 0);
    step(0, 1, 2'd2, 8'h22, 4'b1111, 0);
    chk("bp_next", 64'(out_data[23:16]), 64'h22);
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);

    // Non-blocking: channel 2 stalled full, send to channel 1
    step(0, 1, 2'd2, 8'h77, 4'b1011, 0);
    step(0, 1, 2'd1, 8'h33, 4'b1011, 0);
    chk("nb_ch1", 64'(out_data[15:8]), 64'h33);
    chk("nb_ch2", 64'(out_data[23:16]), 64'h77);
    step(0, 0, 2'd0, 8'h00, 4'b1011, 0);
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);

    // Same-cycle drain and refill on channel 0
    step(0, 1, 2'd0, 8'h44, 4'b1110, 0);
    step(0, 1, 2'd0, 8'h55, 4'b1111, 0);
    chk("refill", 64'({out_valid[0], out_data[7:0]}), 64'({1'b1, 8'h55}));
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);

    // Saturation on channel 3 then clear racing a delivery
    for (int i = 0; i < 20; i++) step(0, 1, 2'd3, 8'(i), 4'hF, 0);
    step(0, 1, 2'd3, 8'hE0, 4'hF, 0);
    chk("sat15", 64'(cnt[15:12]), 64'd15);
    step(0, 0, 2'd0, 8'h00, 4'hF, 1);
    chk("clr_all", 64'(cnt), 64'd0);
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom), 2'($urandom), 8'($urandom),
           4'($urandom), $urandom_range(0, 31) == 0);

    // Reset mid-stream: every channel full and stalled
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);
    step(0, 0, 2'd0, 8'h00, 4'hF, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 8'(8'hF0 + k), 4'h0, 0);
    chk("full_all", 64'(out_valid), 64'hF);
    step(1, 1, 2'd1, 8'hEE, 4'h0, 0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    step(0, 0, 2'd0, 8'h00, 4'hF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer. It routes each word from a single valid/ready input stream to one of four output channels, chosen per word by a 2-bit select. It is the distribution-side counterpart of the team's 4-to-1 `mux4` selector. Each output channel has a one-entry output register and a saturating per-channel delivery counter, so an upstream source can fan out to four independent consumers.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `CNT_W`, 8, width of each per-channel delivery counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `in_sel`  in  2  destination channel for the input word (0..3); sampled only with `in_valid`.
- `in_data`  in  WIDTH  input word.
- `out_valid`  out  4  bit k set: channel k holds a word.
- `out_ready`  in  4  bit k set: consumer k takes channel k's word this cycle.
- `out_data`  out  4*WIDTH  channel k's word is on bits [k*WIDTH +: WIDTH].
- `cnt`  out  4*CNT_W  channel k's delivered-word count is on bits [k*CNT_W +: CNT_W].
- `cnt_clr`  in  1  synchronous clear of all four counters.

## Operation
- Acceptance:
  - `in_ready = !out_valid[in_sel] || out_ready[in_sel]`.
  - This is combinational, and depends only on the selected channel.
  - A transfer occurs when `in_valid && in_ready`.
- Channel k register update, in priority order:
  - If a transfer targets k: `out_data[k] <= in_data` and `out_valid[k] <= 1`.
  - Else, if `out_valid[k] && out_ready[k]`: `out_valid[k] <= 0`, and `out_data[k]` holds.
  - Otherwise: hold.
- Simultaneous drain and refill of the same channel in one cycle: the new word replaces the old one, and `out_valid[k]` stays 1. This gives full throughput, with no bubble.
- Non-selected channels drain independently in the same cycle as any transfer.
- Output stability: while `out_valid[k] && !out_ready[k]`, `out_data[k]` must not change. A new word for k is blocked because `in_ready = 0` when `in_sel == k`.
- Counters:
  - `cnt[k]` increments by 1 on each cycle where channel k's consumer handshake completes (`out_valid[k] && out_ready[k]`).
  - Counters saturate at 2^CNT_W - 1; they do not wrap.
- Counter clear:
  - `cnt_clr` zeroes all counters, and takes priority over an increment in the same cycle.
  - It does not affect `out_valid` or `out_data`.
- Ignored inputs: `in_sel` and `in_data` are don't-care when `in_valid = 0`. `out_ready[k]` is don't-care when `out_valid[k] = 0`.
- Ordering: each channel delivers its words in input order. No ordering is defined between channels.

## Timing
- Reset values (asserted at the clock edge where `rst = 1`):
  - `out_valid = 4'b0000`.
  - `out_data` = all zeros.
  - `cnt` = all zeros.
  - Consequently `in_ready = 1` while `rst` is asserted, and in the first cycle after it.
- Reset mid-operation:
  - Held words are discarded and no counts are recorded.
  - A transfer presented in the same cycle as `rst` is lost; reset wins.
- Latency: a word accepted at edge N is visible on `out_data[k]`, with `out_valid[k] = 1`, immediately after edge N. This is 1 cycle.
- Throughput: 1 word per cycle into any single channel, provided its consumer holds `out_ready[k] = 1`.
- No combinational path from `in_data` or `in_valid` to any output. The only combinational path is `out_valid`/`out_ready`/`in_sel` to `in_ready`.

## Test plan
- Reset and basic routing:
  - Stimulus: assert `rst` for 2 cycles; then send `in_sel` = 0, 1, 2, 3 with `in_data` = 8'hA0, 8'hB1, 8'hC2, 8'hD3, all `out_ready = 4'b1111`.
  - Required: during reset, `out_valid = 0`, `cnt = 0`, `in_ready = 1`. Each word appears on only its channel, one cycle after acceptance. Afterwards every `cnt[k] = 1`.
- Backpressure on a single channel:
  - Stimulus: `out_ready[2] = 0`; send 8'h11 then 8'h22 to channel 2.
  - Required: 8'h11 is held stable. `in_ready` drops to 0 while `in_sel = 2`. Raising `out_ready[2]` delivers 8'h11, then 8'h22 the next cycle.
- Non-blocking across channels:
  - Stimulus: channel 2 stalled and full; send 8'h33 to channel 1.
  - Required: `in_ready = 1` and 8'h33 is delivered on channel 1. Channel 2 still holds its word unchanged.
- Same-cycle drain and refill:
  - Stimulus: channel 0 holds 8'h44 with `out_ready[0] = 1`; 8'h55 is sent to channel 0 in the same cycle.
  - Required: `out_valid[0]` stays 1 and `out_data[0]` becomes 8'h55. `cnt[0]` increments once.
- Counter saturation and clear:
  - Stimulus: `CNT_W` = 4; deliver 20 words to channel 3; then pulse `cnt_clr` in the same cycle as a channel-3 delivery.
  - Required: `cnt[3]` stops at 15. After the clear cycle, `cnt[3] = 0` (clear wins), and the other counters are also 0.
- Reset mid-stream:
  - Stimulus: all four channels full and stalled; assert `rst` for 1 cycle, with a valid input presented in the same cycle.
  - Required: `out_valid = 0` and `cnt = 0` after the edge. The presented word does not appear on any channel.
